// File: rtl/uart_loopback_top.sv
// ---------------------------------------------------------------------------
// uart_loopback_top
//   UART self-test harness: baud-rate generator, 8N1 transmitter and an
//   8x-oversampling receiver whose input is tied to the transmitter output.
//   A byte requested on ready/data is serialised onto tx_data and the same
//   frame is recovered on rx_output.
//
// Parameters
//   BAUD_SEL   0..7; x8 tick divisor DIV8 = 4 << BAUD_SEL clocks
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   ready      in   1   level-sensitive transmit request
//   data       in   8   byte to send, latched at frame launch
//   tx_status  out  1   high while a TX frame is in progress
//   tx_data    out  1   serial line, idle high
//   rx_status  out  1   one-clock pulse when a received frame completes
//   rx_output  out  10  last frame: [0]=start, [8:1]=data LSB-first, [9]=stop
//
// Configuration macro
//   UART_FRAME_CHECK_EN  when defined, frames with a bad start or stop bit are
//                        dropped (no rx_output update, no rx_status pulse).
// ---------------------------------------------------------------------------
module uart_loopback_top #(
  parameter int unsigned BAUD_SEL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       tx_status,
  output logic       tx_data,
  output logic       rx_status,
  output logic [9:0] rx_output
);

  localparam int unsigned DIV8 = 32'd4 << BAUD_SEL;
  localparam int unsigned CW   = $clog2(DIV8);

  // ---------------------------------------------------------------- baud gen
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    x8_cnt_q, x8_cnt_d;
  logic          x8_tick;
  logic          bclk;

  // NOTE: every always_comb output gets a value on every path (here they are
  // all assigned unconditionally), so no latch is inferred.
  always_comb begin
    x8_tick    = (baud_cnt_q == CW'(DIV8 - 1));
    bclk       = x8_tick && (x8_cnt_q == 3'd7);
    baud_cnt_d = x8_tick ? '0 : baud_cnt_q + 1'b1;
    x8_cnt_d   = x8_tick ? x8_cnt_q + 3'd1 : x8_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_q <= '0;
      x8_cnt_q   <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      x8_cnt_q   <= x8_cnt_d;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t  tx_state_q;
  logic [7:0] tx_shift_q;
  logic [2:0] tx_bit_q;
  logic       tx_data_q;
  logic       tx_status_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      tx_data_q   <= 1'b1;
      tx_status_q <= 1'b0;
    end else if (bclk) begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (ready) begin
            tx_shift_q  <= data;
            tx_data_q   <= 1'b0;
            tx_status_q <= 1'b1;
            tx_state_q  <= TX_START;
          end
        end
        TX_START: begin
          tx_data_q  <= tx_shift_q[0];
          tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          tx_bit_q   <= '0;
          tx_state_q <= TX_DATA;
        end
        TX_DATA: begin
          // Line already carries data bit tx_bit_q; bit 7 is followed by stop.
          if (tx_bit_q == 3'd7) begin
            tx_data_q  <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_data_q  <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= tx_bit_q + 3'd1;
          end
        end
        TX_STOP: begin
          // A held request relaunches on the same tick: no idle gap.
          if (ready) begin
            tx_shift_q <= data;
            tx_data_q  <= 1'b0;
            tx_state_q <= TX_START;
          end else begin
            tx_status_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_status = tx_status_q;

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t  rx_state_q;
  logic [2:0] rx_tick_q;
  logic [2:0] rx_idx_q;
  logic [9:0] rx_shift_q;
  logic [9:0] rx_output_q;
  logic       rx_status_q;
  logic       rx_line;
  logic [9:0] frame_d;
  logic       frame_ok;

  assign rx_line = tx_data_q;
  // Bits enter at the MSB so that after ten samples the first bit is at [0].
  assign frame_d = {rx_line, rx_shift_q[9:1]};

`ifdef UART_FRAME_CHECK_EN
  assign frame_ok = (frame_d[0] == 1'b0) && (frame_d[9] == 1'b1);
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_tick_q   <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_output_q <= '0;
      rx_status_q <= 1'b0;
    end else begin
      rx_status_q <= 1'b0;
      if (x8_tick) begin
        unique case (rx_state_q)
          RX_IDLE: begin
            if (!rx_line) begin
              rx_tick_q  <= '0;
              rx_state_q <= RX_START;
            end
          end
          RX_START: begin
            // Fourth tick after the falling edge lands near mid-bit.
            if (rx_tick_q == 3'd3) begin
              if (rx_line) begin
                rx_state_q <= RX_IDLE;
              end else begin
                rx_shift_q <= frame_d;
                rx_tick_q  <= '0;
                rx_idx_q   <= '0;
                rx_state_q <= RX_DATA;
              end
            end else begin
              rx_tick_q <= rx_tick_q + 3'd1;
            end
          end
          RX_DATA: begin
            rx_tick_q <= rx_tick_q + 3'd1;
            if (rx_tick_q == 3'd7) begin
              rx_shift_q <= frame_d;
              rx_idx_q   <= rx_idx_q + 3'd1;
              if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
            end
          end
          RX_STOP: begin
            rx_tick_q <= rx_tick_q + 3'd1;
            if (rx_tick_q == 3'd7) begin
              rx_state_q <= RX_IDLE;
              if (frame_ok) begin
                rx_output_q <= frame_d;
                rx_status_q <= 1'b1;
              end
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx_status = rx_status_q;
  assign rx_output = rx_output_q;

endmodule

// File: tb/tb_uart_loopback_top.sv
// ---------------------------------------------------------------------------
// tb_uart_loopback_top
//   Directed self-checking bench for uart_loopback_top (BAUD_SEL=3: 256
//   clocks per bit). Expected RX frames are queued when a TX launch is seen
//   and popped by a monitor whenever rx_status pulses.
// ---------------------------------------------------------------------------
module tb_uart_loopback_top;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [7:0] data;
  logic       tx_status;
  logic       tx_data;
  logic       rx_status;
  logic [9:0] rx_output;

  uart_loopback_top #(.BAUD_SEL(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .data      (data),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .rx_status (rx_status),
    .rx_output (rx_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks    = 0;
  int         errors    = 0;
  int         rx_pulses = 0;
  bit         rx_prev   = 1'b0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the start bit of a frame; n = negedges waited.
  task automatic wait_tx_fall(output int n);
    n = 0;
    while (tx_data !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Scoreboard consumer: every rx_status pulse must match a queued frame.
  always @(negedge clk) begin
    if (rx_status === 1'b1) begin
      rx_pulses++;
      check("rx_pulse_width", 32'(rx_prev), 32'd0);
      check("rx_frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rx_output", 32'(rx_output), 32'(exp_q.pop_front()));
    end
    rx_prev = (rx_status === 1'b1);
  end

  initial begin
    int         n;
    logic [9:0] frame;

    rst   = 1'b1;
    ready = 1'b0;
    data  = 8'h00;

    // Reset held: outputs at reset values on every cycle.
    repeat (100) begin
      @(negedge clk);
      check("reset_state", 32'({rx_output, rx_status, tx_status, tx_data}),
            32'({10'd0, 1'b0, 1'b0, 1'b1}));
    end

    // Single frame of 0x3D; ready dropped ~640 clocks after release.
    rst   = 1'b0;
    ready = 1'b1;
    data  = 8'h3D;
    wait_tx_fall(n);
    check("first_launch_latency", n, 256);
    frame = {1'b1, 8'h3D, 1'b0};
    exp_q.push_back(frame);
    check("tx_status_launch", 32'(tx_status), 1);
    repeat (128) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      if (b > 0) repeat (256) @(negedge clk);
      check("tx_bit_3d", 32'(tx_data), 32'(frame[b]));
      check("tx_status_busy", 32'(tx_status), 1);
      if (b == 1) ready = 1'b0;
    end
    n = 128 + 9 * 256;
    while (tx_status === 1'b1 && n < 2700) begin
      @(negedge clk);
      n++;
    end
    check("tx_status_width", n, 2560);
    repeat (600) @(negedge clk);
    check("idle_tx_data", 32'(tx_data), 1);
    check("idle_tx_status", 32'(tx_status), 0);
    check("single_frame_rx_count", rx_pulses, 1);
    check("single_frame_queue_empty", exp_q.size(), 0);
    check("rx_output_hold_3d", 32'(rx_output), 32'h27A);

    // Back-to-back: three frames of 0xA5; data disturbed mid-frame.
    data  = 8'hA5;
    ready = 1'b1;
    wait_tx_fall(n);
    check("burst_launch_bounded", 32'(n < 300), 1);
    frame = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back(frame);
    repeat (128) @(negedge clk);
    for (int b = 0; b < 30; b++) begin
      if (b > 0) repeat (256) @(negedge clk);
      if (b > 0 && (b % 10) == 0) exp_q.push_back(frame);
      check("tx_bit_a5", 32'(tx_data), 32'(frame[b % 10]));
      check("tx_status_burst", 32'(tx_status), 1);
      if (b == 3) data = 8'h00;
      if (b == 8) data = 8'hA5;
      if (b == 20) ready = 1'b0;
    end
    n = 0;
    while (tx_status === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("burst_stop_remaining", n, 128);
    repeat (100) @(negedge clk);
    check("burst_rx_count", rx_pulses, 4);
    check("burst_queue_empty", exp_q.size(), 0);
    check("rx_output_a5", 32'(rx_output), 32'h34A);

    // Reset mid-frame aborts TX and RX.
    ready = 1'b1;
    wait_tx_fall(n);
    check("abort_launch_bounded", 32'(n < 300), 1);
    repeat (1000) @(negedge clk);
    check("abort_mid_frame_busy", 32'(tx_status), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_data", 32'(tx_data), 1);
    check("abort_tx_status", 32'(tx_status), 0);
    check("abort_rx_status", 32'(rx_status), 0);
    repeat (10) @(negedge clk);
    check("abort_rx_output_cleared", 32'(rx_output), 0);
    rst   = 1'b0;
    ready = 1'b0;
    repeat (3000) @(negedge clk);
    check("abort_no_rx_pulse", rx_pulses, 4);
    check("abort_line_idle", 32'(tx_data), 1);
    check("abort_status_idle", 32'(tx_status), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
